// File: rtl/bf16_to_int16.sv
// bf16_to_int16
//   Converts a BFloat16 operand to a 16-bit two's-complement fixed-point value
//   y = trunc(a * 2^FRAC_BITS). The result saturates on overflow or infinity.
//   NaN inputs produce zero and raise inv. One operand is accepted per cycle.
//   done pulses three cycles after the capture edge.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  operand valid; a is captured on each edge where start=1
//   a      BFloat16 operand {sign, exp[7:0], mant[6:0]}
//   y      fixed-point result, held between results
//   done   one-cycle result-valid pulse
//   ovf    result saturated (magnitude overflow or infinity)
//   inv    operand was NaN
module bf16_to_int16 #(
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  output logic [15:0] y,
  output logic        done,
  output logic        ovf,
  output logic        inv
);

  // Capture register.
  logic        v0;
  logic [15:0] a0;

  // Stage 1: classification, significand and signed shift amount.
  logic              v1, sign1, zero1, inf1, nan1;
  logic [7:0]        m1;
  logic signed [9:0] sh1;

  // Stage 2: shifted magnitude.
  logic        v2, sign2, zero2, inf2, nan2, big2;
  logic [16:0] mag2;

  // Combinational next-stage values.
  logic [7:0]        exp_c;
  logic signed [9:0] sh_c;
  logic [16:0]       mag_c;
  logic              big_c;
  logic [9:0]        neg_sh;
  logic [15:0]       y_c;
  logic              ovf_c, inv_c;

  // Valid bits are the only state that needs reset. Datapath registers
  // load only when their incoming valid bit is set, so they never need one.
  // NOTE: datapath registers are left unreset on purpose; a stale value can
  // never reach the outputs because every consumer is qualified by a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // stage samples the previous stage's value from before this edge.
      v0 <= start;
      v1 <= v0;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (start && !rst) a0 <= a;
  end

  // Stage 1.
  assign exp_c = a0[14:7];
  assign sh_c  = signed'({2'b00, exp_c}) - 10'sd134 + signed'(10'(FRAC_BITS));

  always_ff @(posedge clk) begin
    if (v0) begin
      sign1 <= a0[15];
      zero1 <= (exp_c == 8'h00);
      inf1  <= (exp_c == 8'hFF) && (a0[6:0] == 7'd0);
      nan1  <= (exp_c == 8'hFF) && (a0[6:0] != 7'd0);
      m1    <= {1'b1, a0[6:0]};
      sh1   <= sh_c;
    end
  end

  // Stage 2: a right shift truncates toward zero because the magnitude
  // is still unsigned here. The sign is applied in stage 3.
  assign neg_sh = 10'(-sh1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    mag_c = 17'd0;
    big_c = 1'b0;
    if (sh1 > 10'sd8) begin
      big_c = 1'b1;
    end else if (sh1 >= 10'sd0) begin
      mag_c = {9'd0, m1} << sh1[3:0];
    end else if (sh1 >= -10'sd7) begin
      mag_c = {9'd0, m1} >> neg_sh[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (v1) begin
      sign2 <= sign1;
      zero2 <= zero1;
      inf2  <= inf1;
      nan2  <= nan1;
      big2  <= big1_mask(big_c, zero1);
      mag2  <= mag_c;
    end
  end

  // A zero-class operand never has a positive shift amount, but it is
  // masked anyway so that zero wins over overflow.
  function automatic logic big1_mask(input logic big, input logic zero);
    return big && !zero;
  endfunction

  // Stage 3: special-case priority, then saturation, then signed result.
  always_comb begin
    y_c   = 16'h0000;
    ovf_c = 1'b0;
    inv_c = 1'b0;
    if (nan2) begin
      inv_c = 1'b1;
    end else if (inf2 || big2) begin
      y_c   = sign2 ? 16'h8000 : 16'h7FFF;
      ovf_c = 1'b1;
    end else if (zero2 || (mag2 == 17'd0)) begin
      y_c = 16'h0000;
    end else if (!sign2 && (mag2 > 17'd32767)) begin
      y_c   = 16'h7FFF;
      ovf_c = 1'b1;
    end else if (sign2 && (mag2 > 17'd32768)) begin
      y_c   = 16'h8000;
      ovf_c = 1'b1;
    end else if (sign2 && (mag2 == 17'd32768)) begin
      y_c = 16'h8000;
    end else begin
      y_c = sign2 ? (~mag2[15:0] + 16'd1) : mag2[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= 16'h0000;
      ovf  <= 1'b0;
      inv  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= v2;
      if (v2) begin
        y   <= y_c;
        ovf <= ovf_c;
        inv <= inv_c;
      end
    end
  end

endmodule

// File: tb/tb_bf16_to_int16.sv
// tb_bf16_to_int16
//   Scoreboard bench for bf16_to_int16. Two instances share the stimulus:
//   one uses FRAC_BITS=0 and the other uses FRAC_BITS=8. A reference model
//   computes each expected result from the real value of the operand and
//   pushes it onto that instance's queue when the operand is driven. A
//   monitor pops and compares each entry when done is observed. It also
//   checks latency, reset values and that y holds between results.
module tb_bf16_to_int16;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    logic        inv;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] a;
  logic [15:0] y_w   [2];
  logic        done_w[2];
  logic        ovf_w [2];
  logic        inv_w [2];
  logic [15:0] last_y[2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bf16_to_int16 #(.FRAC_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .y(y_w[0]), .done(done_w[0]), .ovf(ovf_w[0]), .inv(inv_w[0])
  );

  bf16_to_int16 #(.FRAC_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .y(y_w[1]), .done(done_w[1]), .ovf(ovf_w[1]), .inv(inv_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: value = (128+mant) * 2^(exp-127-7+fb), truncated toward zero,
  // then clamped to the int16 range.
  function automatic exp_t model(input logic [15:0] v, input int fb);
    exp_t   r;
    int     e    = int'(v[14:7]);
    longint sig  = 128 + longint'(v[6:0]);
    int     p    = e - 134 + fb;
    longint mag;
    longint val;
    r.y = 16'h0000; r.ovf = 1'b0; r.inv = 1'b0; r.cyc = 0;
    if (e == 255) begin
      if (v[6:0] != 7'd0) r.inv = 1'b1;
      else begin
        r.y   = v[15] ? 16'h8000 : 16'h7FFF;
        r.ovf = 1'b1;
      end
      return r;
    end
    if (e == 0) return r;
    if (p > 30)       mag = 64'sd1 <<< 40;
    else if (p >= 0)  mag = sig <<< p;
    else if (p < -30) mag = 0;
    else              mag = sig >>> (-p);
    val = v[15] ? -mag : mag;
    if (val > 32767) begin
      r.y = 16'h7FFF; r.ovf = 1'b1;
    end else if (val < -32768) begin
      r.y = 16'h8000; r.ovf = 1'b1;
    end else begin
      r.y = 16'(val);
    end
    return r;
  endfunction

  task automatic drive(input logic s, input logic [15:0] v);
    exp_t e;
    start = s;
    a     = v;
    if (s && !rst) begin
      e = model(v, 0); e.cyc = cyc; q0.push_back(e);
      e = model(v, 8); e.cyc = cyc; q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset(input logic s, input logic [15:0] v);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    drive(s, v);
    rst = 1'b0;
  endtask

  task automatic compare_result(input int k);
    exp_t  e;
    string t;
    t = (k == 0) ? "f0" : "f8";
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      check({t, "_unexpected_done"}, 32'(done_w[k]), 32'd0);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    check({t, "_y"},       32'(y_w[k]),   32'(e.y));
    check({t, "_ovf"},     32'(ovf_w[k]), 32'(e.ovf));
    check({t, "_inv"},     32'(inv_w[k]), 32'(e.inv));
    check({t, "_latency"}, 32'(cyc - e.cyc), 32'd4);
  endtask

  // Monitor, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check("rst_y",    32'(y_w[k]),    32'd0);
        check("rst_done", 32'(done_w[k]), 32'd0);
        check("rst_ovf",  32'(ovf_w[k]),  32'd0);
        check("rst_inv",  32'(inv_w[k]),  32'd0);
      end else if (done_w[k]) begin
        compare_result(k);
      end else begin
        check("hold_y", 32'(y_w[k]), 32'(last_y[k]));
      end
      last_y[k] = y_w[k];
    end
  end

  localparam int N_VEC = 18;
  logic [15:0] vecs [N_VEC] = '{
    16'h3F80, 16'hC020, 16'h3F00, 16'hBF00,            // basic values
    16'h4700, 16'hC700, 16'hC701, 16'h7F80, 16'hFF80,  // saturation
    16'h7FC1, 16'h0001, 16'h8000,                      // special operands
    16'h3FC0, 16'h3B80, 16'h3B00, 16'h4300,            // fractional cases
    16'h46FE, 16'hC6FF                                 // near full scale
  };

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h3F80;
    // A start pulse that arrives while rst is high must be ignored.
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    drive(1'b0, 16'h0000);

    // Single operands, separated by idle cycles.
    for (int i = 0; i < N_VEC; i++) begin
      drive(1'b1, vecs[i]);
      drive(1'b0, 16'h0000);
    end
    repeat (5) drive(1'b0, 16'h0000);

    // Back-to-back stream of 1..6.
    drive(1'b1, 16'h3F80);
    drive(1'b1, 16'h4000);
    drive(1'b1, 16'h4040);
    drive(1'b1, 16'h4080);
    drive(1'b1, 16'h40A0);
    drive(1'b1, 16'h40C0);
    repeat (6) drive(1'b0, 16'h0000);

    // Reset while two operands are in flight: neither may complete.
    drive(1'b1, 16'h4000);
    drive(1'b1, 16'h4040);
    pulse_reset(1'b0, 16'h0000);
    repeat (6) drive(1'b0, 16'h0000);
    check("flush_y", 32'(y_w[0]), 32'd0);
    drive(1'b1, 16'h3F80);
    repeat (5) drive(1'b0, 16'h0000);

    // Random operands, with exponents biased toward the interesting range.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (i % 3 != 0) v[14:7] = 8'($urandom_range(115, 145));
      drive(($urandom_range(0, 3) != 0), v);
    end

    // Drain the queues within a bounded number of cycles.
    for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++)
      drive(1'b0, 16'h0000);
    check("drain", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
